// File: rtl/arbiter_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Contents:
//   N_REQ / SEL_W / HOLD_W : requester count, owner-index width, hold-counter width
//   state_e                : arbiter FSM states
//   onehot()               : owner index -> one-hot grant vector
package arbiter_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRelease = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Bundle between the requesters/mux sink and the arbiter.
// Signals:
//   en            : arbitration enable
//   req[7:0]      : level-sensitive requests, bit k pairs with mux input ik
//   grant[7:0]    : registered one-hot grant, zero when no owner
//   s0, s1, s2    : registered owner index to the 8:1 mux (s0 = LSB)
//   busy          : high exactly when grant is non-zero
// Modports:
//   master : requester / sink side (drives en and req)
//   slave  : arbiter side (drives grant, select lines and busy)
interface rr_arbiter_8_if;
  import arbiter_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic             s0;
  logic             s1;
  logic             s2;
  logic             busy;

  modport master (
    output en, req,
    input  grant, s0, s1, s2, busy
  );

  modport slave (
    input  en, req,
    output grant, s0, s1, s2, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder.
// Ports:
//   req[7:0] : request vector
//   ptr[2:0] : highest-priority position; search order ptr, ptr+1, ... ptr+7 mod 8
//   idx[2:0] : first set request in that order (0 when none)
//   any      : at least one request set
module rr_pick
  import arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    idx   = '0;
    any   = |req;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      // 3-bit add wraps naturally, giving the mod-8 rotation
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter fronting an 8:1 mux. Holds a grant while the owner keeps
// requesting (up to MAX_HOLD cycles) and inserts one dead RELEASE cycle between
// owners so the select lines never change under valid data.
// Parameters:
//   MAX_HOLD : maximum consecutive grant cycles per ownership (1..255)
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : arbiter side of rr_arbiter_8_if (en/req in; grant/s0..s2/busy out)
module rr_arbiter_8
  import arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_8_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              busy_q, busy_d;

  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;

  rr_pick u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;

    unique case (state_q)
      StIdle: begin
        if (bus.en && pick_any) begin
          state_d = StGrant;
          owner_d = pick_idx;
          hold_d  = '0;
        end
      end
      StGrant: begin
        // Other requesters never pre-empt; only owner drop or hold limit end it.
        if (!bus.req[owner_q] || (hold_q == HoldLast)) begin
          state_d = StRelease;
          ptr_d   = owner_q + SEL_W'(1);
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      StRelease: begin
        // ptr_q was already advanced past the old owner, so pick sees it last.
        if (bus.en && pick_any) begin
          state_d = StGrant;
          owner_d = pick_idx;
          hold_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered versions of the next state, so grant appears
    // one edge after the request is sampled.
    busy_d  = (state_d == StGrant);
    grant_d = busy_d ? onehot(owner_d) : '0;
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.s0    = owner_q[0];
  assign bus.s1    = owner_q[1];
  assign bus.s2    = owner_q[2];

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;
  import arbiter_pkg::*;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic       busy;
    logic [2:0] sel;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  vec_t tbl_main[$];
  vec_t tbl_post[$];

  rr_arbiter_8_if a16 ();
  rr_arbiter_8_if a4 ();

  rr_arbiter_8 #(.MAX_HOLD(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (a16)
  );

  rr_arbiter_8 #(.MAX_HOLD(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (a4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s #%0d got %0h want %0h", nm, id, got, exp);
    end
  endtask

  task automatic add_main(input logic r, input logic e, input logic [7:0] q,
                          input logic [7:0] g, input logic b, input logic [2:0] s);
    tbl_main.push_back('{rst: r, en: e, req: q, grant: g, busy: b, sel: s});
  endtask

  task automatic add_post(input logic r, input logic e, input logic [7:0] q,
                          input logic [7:0] g, input logic b, input logic [2:0] s);
    tbl_post.push_back('{rst: r, en: e, req: q, grant: g, busy: b, sel: s});
  endtask

  // Drive one vector at the falling edge, check just after the next rising edge.
  task automatic run_vec(input bit use4, input vec_t v, input string nm, input int id);
    @(negedge clk);
    rst = v.rst;
    if (use4) begin
      a4.en   = v.en;
      a4.req  = v.req;
      a16.req = 8'h00;
    end else begin
      a16.en  = v.en;
      a16.req = v.req;
      a4.req  = 8'h00;
    end
    @(posedge clk);
    #1;
    if (use4) begin
      chk({nm, ".grant"}, id, 32'(a4.grant), 32'(v.grant));
      chk({nm, ".busy"},  id, 32'(a4.busy),  32'(v.busy));
      chk({nm, ".sel"},   id, 32'({a4.s2, a4.s1, a4.s0}), 32'(v.sel));
    end else begin
      chk({nm, ".grant"}, id, 32'(a16.grant), 32'(v.grant));
      chk({nm, ".busy"},  id, 32'(a16.busy),  32'(v.busy));
      chk({nm, ".sel"},   id, 32'({a16.s2, a16.s1, a16.s0}), 32'(v.sel));
    end
  endtask

  initial begin
    vec_t v;
    int   gcnt[8];
    int   owner;
    int   phase;

    a16.en  = 1'b1;
    a16.req = 8'hFF;
    a4.en   = 1'b1;
    a4.req  = 8'h00;

    // rst, en, req, grant, busy, sel  (MAX_HOLD=16 instance)
    add_main(1, 1, 8'hFF, 8'h00, 0, 3'd0);  // held in reset
    add_main(1, 1, 8'hFF, 8'h00, 0, 3'd0);
    add_main(0, 1, 8'hFF, 8'h01, 1, 3'd0);  // first edge after reset: ptr=0
    add_main(0, 1, 8'h00, 8'h00, 0, 3'd0);  // release, ptr=1
    add_main(0, 1, 8'h00, 8'h00, 0, 3'd0);  // idle
    for (int i = 0; i < 5; i++) add_main(0, 1, 8'h20, 8'h20, 1, 3'd5);
    add_main(0, 1, 8'h00, 8'h00, 0, 3'd5);  // release keeps select
    add_main(0, 1, 8'h00, 8'h00, 0, 3'd5);  // idle keeps select
    add_main(0, 0, 8'h10, 8'h00, 0, 3'd5);  // en low blocks grant
    add_main(0, 0, 8'h10, 8'h00, 0, 3'd5);
    add_main(0, 1, 8'h10, 8'h10, 1, 3'd4);
    for (int i = 0; i < 3; i++) add_main(0, 0, 8'h10, 8'h10, 1, 3'd4);  // en low mid-grant
    add_main(0, 0, 8'h00, 8'h00, 0, 3'd4);  // owner drop, ptr=5
    add_main(0, 0, 8'h00, 8'h00, 0, 3'd4);
    add_main(0, 1, 8'h10, 8'h10, 1, 3'd4);
    add_main(0, 1, 8'h04, 8'h00, 0, 3'd4);  // owner drops, other waiting: dead cycle
    add_main(0, 1, 8'h04, 8'h04, 1, 3'd2);

    add_post(1, 1, 8'h84, 8'h00, 0, 3'd0);  // still in reset
    add_post(0, 1, 8'h84, 8'h04, 1, 3'd2);  // ptr back to 0: bit 2 before bit 7
    add_post(0, 1, 8'h00, 8'h00, 0, 3'd2);
    add_post(0, 1, 8'h00, 8'h00, 0, 3'd2);

    foreach (tbl_main[i]) run_vec(1'b0, tbl_main[i], "main", i);

    // Async reset while grant=04: outputs must fall before any clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async.grant", 0, 32'(a16.grant), 32'h00);
    chk("async.busy",  0, 32'(a16.busy),  32'h0);
    chk("async.sel",   0, 32'({a16.s2, a16.s1, a16.s0}), 32'h0);

    foreach (tbl_post[i]) run_vec(1'b0, tbl_post[i], "post", i);

    // Rotation on MAX_HOLD=4: 01 x4, dead, 80 x4, dead, ...
    for (int c = 0; c < 20; c++) begin
      phase = c % 10;
      v.rst = 1'b0;
      v.en  = 1'b1;
      v.req = 8'h81;
      if (phase < 4)      begin v.grant = 8'h01; v.busy = 1'b1; v.sel = 3'd0; end
      else if (phase == 4) begin v.grant = 8'h00; v.busy = 1'b0; v.sel = 3'd0; end
      else if (phase < 9) begin v.grant = 8'h80; v.busy = 1'b1; v.sel = 3'd7; end
      else                begin v.grant = 8'h00; v.busy = 1'b0; v.sel = 3'd7; end
      run_vec(1'b1, v, "rot", c);
    end
    v = '{rst: 0, en: 1, req: 8'h00, grant: 8'h00, busy: 0, sel: 3'd7};
    run_vec(1'b1, v, "rot_idle", 0);

    // Hold limit and owner drop on the same edge: single release, ptr=owner+1.
    for (int c = 0; c < 4; c++) begin
      v = '{rst: 0, en: 1, req: 8'h08, grant: 8'h08, busy: 1, sel: 3'd3};
      run_vec(1'b1, v, "coin", c);
    end
    v = '{rst: 0, en: 1, req: 8'h00, grant: 8'h00, busy: 0, sel: 3'd3};
    run_vec(1'b1, v, "coin", 4);
    v = '{rst: 0, en: 1, req: 8'h28, grant: 8'h20, busy: 1, sel: 3'd5};
    run_vec(1'b1, v, "coin", 5);
    v = '{rst: 0, en: 1, req: 8'h00, grant: 8'h00, busy: 0, sel: 3'd5};
    run_vec(1'b1, v, "coin", 6);
    run_vec(1'b1, v, "coin", 7);

    // Fairness: all requesting, starting from ptr=6; period 8*(4+1) = 40.
    for (int k = 0; k < 8; k++) gcnt[k] = 0;
    for (int c = 0; c < 40; c++) begin
      owner = (6 + c / 5) % 8;
      phase = c % 5;
      v.rst = 1'b0;
      v.en  = 1'b1;
      v.req = 8'hFF;
      v.sel = 3'(owner);
      if (phase < 4) begin
        v.grant = 8'h01 << owner;
        v.busy  = 1'b1;
      end else begin
        v.grant = 8'h00;
        v.busy  = 1'b0;
      end
      run_vec(1'b1, v, "fair", c);
      for (int k = 0; k < 8; k++) if (a4.grant[k]) gcnt[k]++;
    end
    for (int k = 0; k < 8; k++) chk("fair.count", k, 32'(gcnt[k]), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
